mmio_button_in: RTL
===================

Name: mmio_button_in

Overview:
- Memory-mapped input responder for the single-cycle core. The core's memory-mapped LED register is output-only; this block provides the matching input path.
- Synchronizes and debounces raw board buttons, latches press events, and answers core loads and stores at two fixed word addresses.
- Sits beside DataMemory on the core's data-address, write-enable and write-data bus. The core uses hit_o to select this block's data_o instead of memory data on loads.

Parameters:
- XLEN, 32, bus data and address width.
- N_BTN, 2, number of button inputs (N_BTN <= XLEN).
- DEBOUNCE_CYCLES, 270000, number of consecutive cycles the synced input must differ from the stable level before it is accepted (10 ms at 27 MHz); must be >= 2.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; the block inverts so internal level 1 = pressed.
- STATE_ADDR, 62, word address of the debounced level register (read-only).
- EDGE_ADDR, 61, word address of the sticky press-flag register (read, write-1-to-clear).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, synchronous, active-high.
- btn_i  input  N_BTN  raw asynchronous button pins.
- addr_i  input  XLEN  data address from the core ALU.
- we_i  input  1  store strobe from the core.
- data_i  input  XLEN  store data from the core.
- data_o  output  XLEN  read data (combinational).
- hit_o  output  1  addr_i equals STATE_ADDR or EDGE_ADDR (combinational).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. All state updates on the rising edge of clk_i.
- Reset values (on any clock edge with rst_i=1):
  - sync stages = released level;
  - stable levels = 0;
  - per-button counters = 0;
  - edge flags = 0.
  - Reset mid-debounce abandons the count. Reset with a button held: the press is re-detected after 2+DEBOUNCE_CYCLES cycles and sets its flag.
- Synchronizer: 2-flop per button, with polarity applied after the flops. Synced level s[i] lags btn_i by 2 edges.
- Debounce, per button i (counter width = $clog2(DEBOUNCE_CYCLES)):
  - If s[i] == stable[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable[i] <= s[i] and counter <= 0.
  - Else: counter <= counter+1.
  - Net effect: stable[i] flips on the DEBOUNCE_CYCLES-th consecutive mismatching edge. A single matching cycle restarts the count.
- Press detect: edge flag[i] is set on the same edge that stable[i] goes 0->1. Release (1->0) never sets a flag.
- Register access:
  - Read at STATE_ADDR: data_o = zero-extended stable[N_BTN-1:0].
  - Read at EDGE_ADDR: data_o = zero-extended flag[N_BTN-1:0].
  - Any other address: data_o = 0 and hit_o = 0.
  - Reads are combinational with no side effects; the value reflects registers before the current edge.
- Write-1-to-clear: with we_i=1 and addr_i=EDGE_ADDR, flag[i] <= 0 for each data_i[i]=1. Bits with data_i=0 and bits >= N_BTN are ignored.
- Simultaneous set and clear of the same flag bit in one cycle: set wins (flag = 1), so no press is lost.
- Stores to STATE_ADDR or to non-hit addresses: no effect.
- Address compare uses the full XLEN bits; no aliasing.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, N_BTN=2):
- Reset: hold rst_i 2 cycles with btn_i=2'b11 -> reading addr 62 gives 0 and reading addr 61 gives 0. hit_o=1 at 61 and 62; hit_o=0 and data_o=0 at addr 60.
- Clean press: btn_i[0] 1->0 at edge 0 -> stable bit 0 reads 1 and flag bit 0 reads 1 starting after edge 6 (2 sync + 4 debounce), not before. Holding btn_i[0] at 0 thereafter causes no change.
- Bounce: btn_i[0] low for 3 cycles, high 1 cycle, then low steadily -> no early acceptance; stable goes to 1 exactly 4 edges after s[0] stays low, and the flag is set once.
- Release: after the press in the clean-press scenario, btn_i[0] 0->1 -> stable bit 0 returns to 0 after 6 edges; flag bit 0 stays 1.
- W1C: flags=2'b11, store data_i=32'h1 to addr 61 -> flags=2'b10. A store of 32'hFFFF_FFFF to addr 62 leaves flags unchanged.
- Set/clear race: W1C of bit 1 issued on the same edge that stable[1] rises -> flag bit 1 reads 1 afterwards.

Source files
------------

// File: rtl/mmio_button_in.sv
// Button input responder for the core's data bus: 2-flop sync, debounce,
// sticky press flags, readable at two fixed word addresses.
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   btn_i   raw asynchronous button pins
//   addr_i  data address from the core
//   we_i    store strobe
//   data_i  store data (write-1-to-clear mask at EDGE_ADDR)
//   data_o  combinational read data
//   hit_o   addr_i selects this block
module mmio_button_in #(
  parameter int XLEN            = 32,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int STATE_ADDR      = 62,
  parameter int EDGE_ADDR       = 61
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic             we_i,
  input  logic [XLEN-1:0]  data_i,
  output logic [XLEN-1:0]  data_o,
  output logic             hit_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [XLEN-1:0] ST_A = XLEN'(STATE_ADDR);
  localparam logic [XLEN-1:0] ED_A = XLEN'(EDGE_ADDR);

  // Raw pin level when nobody is pressing.
  localparam logic [N_BTN-1:0] RELEASED =
    ACTIVE_LOW ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] flag_q, flag_d;
  logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;

  logic [N_BTN-1:0] s;
  logic             hit_st;
  logic             hit_ed;

  assign hit_st = (addr_i == ST_A);
  assign hit_ed = (addr_i == ED_A);
  assign hit_o  = hit_st | hit_ed;

  // Polarity applied after the flops: 1 = pressed.
  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    sync1_d  = btn_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;

    if (we_i && hit_ed) begin
      flag_d = flag_q & ~data_i[N_BTN-1:0];
    end

    for (int i = 0; i < N_BTN; i++) begin
      if (s[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s[i];
        cnt_d[i]    = '0;
        // Applied after the clear so a press is never lost.
        if (s[i]) begin
          flag_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= RELEASED;
      sync2_q  <= RELEASED;
      stable_q <= '0;
      cnt_q    <= '0;
      flag_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    data_o = '0;
    unique case (1'b1)
      hit_st:  data_o[N_BTN-1:0] = stable_q;
      hit_ed:  data_o[N_BTN-1:0] = flag_q;
      default: data_o = '0;
    endcase
  end

  generate
    if (N_BTN < XLEN) begin : g_unused
      logic unused_data_hi;
      assign unused_data_hi = ^data_i[XLEN-1:N_BTN];
    end
  endgenerate

endmodule
